// File: rtl/cpu_pkg.sv
// Shared CPU types and default widths for the memory-side stage.
// The state enum is shared so datapath debug views decode the same encoding.
package cpu_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT,
    DONE
  } mem_state_t;

  // Width of a down-counter that must hold the larger of the two latencies.
  function automatic int lat_cnt_w(input int rd_lat, input int wr_lat);
    int m;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mem_interface_if.sv
// Bus between the memory-side stage (master) and the synchronous RAM (slave).
interface mem_interface_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rd;
  logic              mem_wr;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_rd,
    output mem_wr,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_rd,
    input  mem_wr,
    output mem_rdata
  );

endinterface

// File: rtl/mem_interface_mdr_reg.sv
// Memory data register: loads either RAM read data or the datapath bus.
// Memory capture wins; the controller never asserts both loads together.
module mdr_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_ld_i,
  input  logic              mem_ld_i,
  input  logic [DATA_W-1:0] bus_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] mdr_o
);

  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] mdr_d;

  always_comb begin
    mdr_d = mdr_q;
    if (mem_ld_i) begin
      mdr_d = rdata_i;
    end else if (bus_ld_i) begin
      mdr_d = bus_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdr_q <= '0;
    end else begin
      mdr_q <= mdr_d;
    end
  end

  assign mdr_o = mdr_q;

endmodule

// File: rtl/mem_interface.sv
// Memory-side stage: MAR/MDR plus a one-shot, latency-aware access FSM that
// turns level read/write requests from the control unit into single RAM strobes.
module mem_interface
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              read,
  input  logic              wren,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  mem_interface_if.master   mem
);

  localparam int               CNT_W   = lat_cnt_w(RD_LAT, WR_LAT);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              read_q, wren_q;
  logic              err_q, err_d;

  logic              rd_rise, wr_rise;
  logic              idle;
  logic              mdr_bus_ld, mdr_mem_ld;
  logic              proto_viol;
  logic [DATA_W-1:0] mdr;

  // A held level only starts one access: compare against last cycle's level.
  assign rd_rise    = read & ~read_q;
  assign wr_rise    = wren & ~wren_q;
  assign idle       = (state_q == IDLE);
  assign mdr_bus_ld = MDRin & ~read & idle;

  // Any bus-side request or register load while an access is in flight.
  assign proto_viol = ~idle & (rd_rise | wr_rise | MARin | (MDRin & ~read));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mdr_mem_ld = 1'b0;
    mar_d      = (MARin && idle) ? bus_in[ADDR_W-1:0] : mar_q;
    err_d      = err_q | proto_viol | (idle & rd_rise & wr_rise);

    case (state_q)
      IDLE: begin
        if (wr_rise) begin
          state_d = WR_ISSUE;
        end else if (rd_rise) begin
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        cnt_d   = RD_LOAD;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          mdr_mem_ld = 1'b1;
          state_d    = DONE;
        end
      end
      WR_ISSUE: begin
        cnt_d   = WR_LOAD;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      read_q  <= 1'b0;
      wren_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      read_q  <= read;
      wren_q  <= wren;
      err_q   <= err_d;
    end
  end

  mdr_reg #(
    .DATA_W (DATA_W)
  ) u_mdr (
    .clk      (clk),
    .reset    (reset),
    .bus_ld_i (mdr_bus_ld),
    .mem_ld_i (mdr_mem_ld),
    .bus_i    (bus_in),
    .rdata_i  (mem.mem_rdata),
    .mdr_o    (mdr)
  );

  // Strobes and status decode straight from the state register: glitch-free.
  assign mem.mem_rd    = (state_q == RD_ISSUE);
  assign mem.mem_wr    = (state_q == WR_ISSUE);
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr;
  assign mdr_out       = mdr;
  assign busy          = ~idle;
  assign done          = (state_q == DONE);
  assign err           = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: two instances (short and long latency) driven by
// randomized transactions and checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_mem_interface;
  import cpu_pkg::*;

  localparam int AW   = DEF_ADDR_W;
  localparam int DW   = DEF_DATA_W;
  localparam int A_RD = 1;
  localparam int A_WR = 1;
  localparam int B_RD = 4;
  localparam int B_WR = 2;
  localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] a_bus, b_bus;
  logic          a_marin, a_mdrin, a_read, a_wren;
  logic          b_marin, b_mdrin, b_read, b_wren;
  logic [DW-1:0] a_mdr, b_mdr;
  logic          a_busy, a_done, a_err, b_busy, b_done, b_err;

  mem_interface_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
  mem_interface_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

  mem_interface #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(A_RD), .WR_LAT(A_WR)) dut_a (
    .clk(clk), .reset(rst_n), .bus_in(a_bus), .MARin(a_marin), .MDRin(a_mdrin),
    .read(a_read), .wren(a_wren), .mdr_out(a_mdr), .busy(a_busy), .done(a_done),
    .err(a_err), .mem(ifa)
  );

  mem_interface #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(B_RD), .WR_LAT(B_WR)) dut_b (
    .clk(clk), .reset(rst_n), .bus_in(b_bus), .MARin(b_marin), .MDRin(b_mdrin),
    .read(b_read), .wren(b_wren), .mdr_out(b_mdr), .busy(b_busy), .done(b_done),
    .err(b_err), .mem(ifb)
  );

  // RAM models: sample strobes on the rising edge, read data valid RD_LAT edges later.
  logic [DW-1:0] ram_a [0:511];
  logic [DW-1:0] ram_b [0:511];
  logic          poke_a, poke_b;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;
  logic          va_p [A_RD];
  logic [DW-1:0] da_p [A_RD];
  logic          vb_p [B_RD];
  logic [DW-1:0] db_p [B_RD];

  always @(posedge clk) begin
    if (poke_a) ram_a[poke_addr] <= poke_data;
    else if (ifa.mem_wr) ram_a[ifa.mem_addr] <= ifa.mem_wdata;
    va_p[0] <= ifa.mem_rd;
    da_p[0] <= ram_a[ifa.mem_addr];
    for (int i = 1; i < A_RD; i++) begin
      va_p[i] <= va_p[i-1];
      da_p[i] <= da_p[i-1];
    end
  end

  always @(posedge clk) begin
    if (poke_b) ram_b[poke_addr] <= poke_data;
    else if (ifb.mem_wr) ram_b[ifb.mem_addr] <= ifb.mem_wdata;
    vb_p[0] <= ifb.mem_rd;
    db_p[0] <= ram_b[ifb.mem_addr];
    for (int i = 1; i < B_RD; i++) begin
      vb_p[i] <= vb_p[i-1];
      db_p[i] <= db_p[i-1];
    end
  end

  assign ifa.mem_rdata = va_p[A_RD-1] ? da_p[A_RD-1] : POISON;
  assign ifb.mem_rdata = vb_p[B_RD-1] ? db_p[B_RD-1] : POISON;

  // Pulse/event monitors sampled mid-cycle.
  int            a_rd_n = 0, a_wr_n = 0, a_done_n = 0;
  int            b_rd_n = 0, b_wr_n = 0, b_done_n = 0, b_busy_n = 0;
  logic [AW-1:0] a_rd_addr, a_wr_addr;
  logic [DW-1:0] a_wr_data, b_wr_data;

  always @(negedge clk) begin
    if (ifa.mem_rd) begin a_rd_n <= a_rd_n + 1; a_rd_addr <= ifa.mem_addr; end
    if (ifa.mem_wr) begin a_wr_n <= a_wr_n + 1; a_wr_addr <= ifa.mem_addr; a_wr_data <= ifa.mem_wdata; end
    if (a_done) a_done_n <= a_done_n + 1;
    if (ifb.mem_rd) b_rd_n <= b_rd_n + 1;
    if (ifb.mem_wr) begin b_wr_n <= b_wr_n + 1; b_wr_data <= ifb.mem_wdata; end
    if (b_done) b_done_n <= b_done_n + 1;
    if (b_busy) b_busy_n <= b_busy_n + 1;
  end

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] ref_mem [0:511];
  logic [AW-1:0] wr_q [$];

  task automatic nstep(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic poke(input bit which_b, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    poke_addr = addr;
    poke_data = data;
    if (which_b) poke_b = 1'b1; else poke_a = 1'b1;
    nstep(1);
    poke_a = 1'b0;
    poke_b = 1'b0;
    if (!which_b) ref_mem[addr] = data;
  endtask

  task automatic idle_inputs();
    a_marin = 1'b0; a_mdrin = 1'b0; a_read = 1'b0; a_wren = 1'b0;
    b_marin = 1'b0; b_mdrin = 1'b0; b_read = 1'b0; b_wren = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst_n = 1'b0;
    nstep(1);
    rst_n = 1'b1;
    nstep(1);
  endtask

  task automatic a_load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_bus = ($urandom & ~32'h1FF) | 32'(addr);
    a_marin = 1'b1;
    nstep(1);
    a_marin = 1'b0;
    a_bus = data;
    a_mdrin = 1'b1;
    nstep(1);
    a_mdrin = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    nstep(2);
    tests++;
    if ({a_busy, a_done, a_err, ifa.mem_rd, ifa.mem_wr} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl_a: busy/done/err/rd/wr got %b want 00000",
               {a_busy, a_done, a_err, ifa.mem_rd, ifa.mem_wr});
    end
    tests++;
    if (a_mdr !== '0 || ifa.mem_addr !== '0 || ifa.mem_wdata !== '0) begin
      fails++;
      $display("FAIL reset_regs_a: mdr=%h addr=%h wdata=%h want all 0", a_mdr, ifa.mem_addr, ifa.mem_wdata);
    end
    tests++;
    if ({b_busy, b_done, b_err} !== 3'b0 || b_mdr !== '0 || ifb.mem_addr !== '0) begin
      fails++;
      $display("FAIL reset_b: busy/done/err=%b mdr=%h addr=%h want 0", {b_busy, b_done, b_err}, b_mdr, ifb.mem_addr);
    end
    rst_n = 1'b1;
    nstep(2);
    tests++;
    if ({a_busy, b_busy} !== 2'b00) begin
      fails++;
      $display("FAIL reset_release: busy a/b got %b want 00", {a_busy, b_busy});
    end
  endtask

  task automatic test_write();
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int wr0, dn0;
    for (int k = 0; k < 5; k++) begin
      addr = (k == 0) ? 9'h1F0 : AW'($urandom_range(1, 511));
      data = (k == 0) ? 32'h1234_5678 : $urandom;
      a_bus = ($urandom & ~32'h1FF) | 32'(addr);
      a_marin = 1'b1;
      nstep(1);
      a_marin = 1'b0;
      a_bus = data;
      a_mdrin = 1'b1;
      // Odd iterations load MDR on the same edge as the write request.
      if (k % 2 == 0) begin
        nstep(1);
        a_mdrin = 1'b0;
      end
      wr0 = a_wr_n;
      dn0 = a_done_n;
      a_wren = 1'b1;
      nstep(1);
      a_mdrin = 1'b0;
      a_bus = $urandom;
      tests++;
      if (ifa.mem_wr !== 1'b1 || a_busy !== 1'b1 || ifa.mem_addr !== addr || ifa.mem_wdata !== data) begin
        fails++;
        $display("FAIL wr_issue k=%0d: wr=%b busy=%b addr=%h data=%h want 1 1 %h %h",
                 k, ifa.mem_wr, a_busy, ifa.mem_addr, ifa.mem_wdata, addr, data);
      end
      nstep(A_WR);
      tests++;
      if (a_done !== 1'b0 || ifa.mem_wr !== 1'b0) begin
        fails++;
        $display("FAIL wr_wait k=%0d: done=%b wr=%b want 0 0", k, a_done, ifa.mem_wr);
      end
      nstep(1);
      tests++;
      if (a_done !== 1'b1) begin
        fails++;
        $display("FAIL wr_done k=%0d: done=%b want 1", k, a_done);
      end
      nstep(1);
      a_wren = 1'b0;
      tests++;
      if ({a_done, a_busy} !== 2'b00) begin
        fails++;
        $display("FAIL wr_end k=%0d: done/busy=%b want 00", k, {a_done, a_busy});
      end
      nstep(1);
      tests++;
      if (a_wr_n - wr0 != 1 || a_done_n - dn0 != 1 || a_wr_addr !== addr || a_wr_data !== data) begin
        fails++;
        $display("FAIL wr_once k=%0d: pulses=%0d dones=%0d addr=%h data=%h want 1 1 %h %h",
                 k, a_wr_n - wr0, a_done_n - dn0, a_wr_addr, a_wr_data, addr, data);
      end
      ref_mem[addr] = data;
      wr_q.push_back(addr);
    end
  endtask

  task automatic test_read();
    logic [AW-1:0] addrs [$];
    logic [AW-1:0] addr;
    logic [DW-1:0] prev;
    int rd0, dn0;
    addrs.push_back(9'h055);
    foreach (wr_q[i]) addrs.push_back(wr_q[i]);
    poke(1'b0, 9'h055, 32'hDEAD_BEEF);
    foreach (addrs[i]) begin
      addr = addrs[i];
      a_bus = ($urandom & ~32'h1FF) | 32'(addr);
      a_marin = 1'b1;
      nstep(1);
      a_marin = 1'b0;
      a_bus = $urandom;
      prev = a_mdr;
      rd0 = a_rd_n;
      dn0 = a_done_n;
      a_read = 1'b1;
      a_mdrin = 1'b1;
      nstep(1);
      tests++;
      if ({ifa.mem_rd, a_busy} !== 2'b11 || ifa.mem_addr !== addr) begin
        fails++;
        $display("FAIL rd_issue i=%0d: rd/busy=%b addr=%h want 11 %h", i, {ifa.mem_rd, a_busy}, ifa.mem_addr, addr);
      end
      nstep(1);
      tests++;
      if (ifa.mem_rd !== 1'b0 || a_mdr !== prev || a_done !== 1'b0) begin
        fails++;
        $display("FAIL rd_wait i=%0d: rd=%b mdr=%h done=%b want 0 %h 0", i, ifa.mem_rd, a_mdr, a_done, prev);
      end
      nstep(1);
      tests++;
      if (a_mdr !== ref_mem[addr] || a_done !== 1'b1) begin
        fails++;
        $display("FAIL rd_data i=%0d: mdr=%h done=%b want %h 1", i, a_mdr, a_done, ref_mem[addr]);
      end
      a_read = 1'b0;
      a_mdrin = 1'b0;
      nstep(1);
      tests++;
      if ({a_done, a_busy} !== 2'b00 || a_rd_n - rd0 != 1 || a_done_n - dn0 != 1 || a_rd_addr !== addr) begin
        fails++;
        $display("FAIL rd_once i=%0d: done/busy=%b rd_pulses=%0d dones=%0d addr=%h want 00 1 1 %h",
                 i, {a_done, a_busy}, a_rd_n - rd0, a_done_n - dn0, a_rd_addr, addr);
      end
    end
  endtask

  task automatic test_conflict();
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int rd0, wr0;
    tests++;
    if (a_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clean: err=%b want 0", a_err);
    end
    addr = AW'($urandom_range(1, 511));
    data = $urandom;
    a_load(addr, data);
    rd0 = a_rd_n;
    wr0 = a_wr_n;
    a_read = 1'b1;
    a_wren = 1'b1;
    nstep(1);
    tests++;
    if ({ifa.mem_wr, ifa.mem_rd} !== 2'b10) begin
      fails++;
      $display("FAIL conflict_issue: wr/rd=%b want 10", {ifa.mem_wr, ifa.mem_rd});
    end
    nstep(A_WR + 2);
    a_read = 1'b0;
    a_wren = 1'b0;
    nstep(1);
    tests++;
    if (a_rd_n != rd0 || a_wr_n - wr0 != 1 || a_wr_data !== data || a_err !== 1'b1) begin
      fails++;
      $display("FAIL conflict: rd_pulses=%0d wr_pulses=%0d data=%h err=%b want 0 1 %h 1",
               a_rd_n - rd0, a_wr_n - wr0, a_wr_data, a_err, data);
    end
    ref_mem[addr] = data;
    a_read = 1'b1;
    a_mdrin = 1'b1;
    nstep(3);
    a_read = 1'b0;
    a_mdrin = 1'b0;
    nstep(2);
    tests++;
    if (a_mdr !== ref_mem[addr] || a_err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: mdr=%h err=%b want %h 1", a_mdr, a_err, ref_mem[addr]);
    end
  endtask

  task automatic test_proto_err();
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int dn0, rd0, wr0;
    pulse_reset();
    tests++;
    if (a_err !== 1'b0) begin
      fails++;
      $display("FAIL err_reset_clear: err=%b want 0", a_err);
    end
    // MARin during a read.
    addr = wr_q[0];
    if (addr == 9'h0AA) addr = 9'h055;
    a_bus = 32'(addr);
    a_marin = 1'b1;
    nstep(1);
    a_marin = 1'b0;
    dn0 = a_done_n;
    a_read = 1'b1;
    a_mdrin = 1'b1;
    nstep(1);
    a_bus = 32'h0000_00AA;
    a_marin = 1'b1;
    nstep(1);
    a_marin = 1'b0;
    tests++;
    if (ifa.mem_addr !== addr) begin
      fails++;
      $display("FAIL mar_busy: addr=%h want %h", ifa.mem_addr, addr);
    end
    nstep(1);
    a_read = 1'b0;
    a_mdrin = 1'b0;
    nstep(2);
    tests++;
    if (a_mdr !== ref_mem[addr] || a_done_n - dn0 != 1 || a_err !== 1'b1 || ifa.mem_addr !== addr) begin
      fails++;
      $display("FAIL proto_mar: mdr=%h dones=%0d err=%b addr=%h want %h 1 1 %h",
               a_mdr, a_done_n - dn0, a_err, ifa.mem_addr, ref_mem[addr], addr);
    end
    // MDR bus load during a write.
    pulse_reset();
    addr = AW'($urandom_range(1, 511));
    data = $urandom;
    a_load(addr, data);
    a_wren = 1'b1;
    nstep(1);
    a_bus = ~data;
    a_mdrin = 1'b1;
    nstep(1);
    a_mdrin = 1'b0;
    nstep(A_WR + 1);
    a_wren = 1'b0;
    nstep(1);
    tests++;
    if (a_mdr !== data || a_wr_data !== data || a_err !== 1'b1) begin
      fails++;
      $display("FAIL proto_mdr: mdr=%h wdata=%h err=%b want %h %h 1", a_mdr, a_wr_data, a_err, data, data);
    end
    ref_mem[addr] = data;
    // Read request rising while a write is in flight.
    pulse_reset();
    addr = AW'($urandom_range(1, 511));
    data = $urandom;
    a_load(addr, data);
    rd0 = a_rd_n;
    wr0 = a_wr_n;
    a_wren = 1'b1;
    nstep(1);
    a_read = 1'b1;
    nstep(A_WR + 2);
    a_wren = 1'b0;
    nstep(2);
    a_read = 1'b0;
    nstep(1);
    tests++;
    if (a_rd_n != rd0 || a_wr_n - wr0 != 1 || a_err !== 1'b1 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL proto_rise: rd_pulses=%0d wr_pulses=%0d err=%b busy=%b want 0 1 1 0",
               a_rd_n - rd0, a_wr_n - wr0, a_err, a_busy);
    end
    ref_mem[addr] = data;
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] addr;
    int dn0;
    pulse_reset();
    addr = AW'($urandom_range(1, 511));
    poke(1'b0, addr, $urandom);
    a_load(addr, $urandom | 32'h1);
    a_read = 1'b1;
    a_mdrin = 1'b1;
    nstep(2);
    dn0 = a_done_n;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a_busy, ifa.mem_rd, a_done} !== 3'b000 || ifa.mem_addr !== '0 || a_mdr !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy/rd/done=%b addr=%h mdr=%h want 000 0 0",
               {a_busy, ifa.mem_rd, a_done}, ifa.mem_addr, a_mdr);
    end
    a_read = 1'b0;
    a_mdrin = 1'b0;
    nstep(1);
    rst_n = 1'b1;
    nstep(4);
    tests++;
    if (a_done_n != dn0 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_done: dones=%0d busy=%b want 0 0", a_done_n - dn0, a_busy);
    end
  endtask

  task automatic test_latency();
    logic [AW-1:0] addr;
    logic [DW-1:0] pre, data;
    int bz0, dn0, rd0, wr0;
    for (int k = 0; k < 2; k++) begin
      addr = AW'($urandom_range(0, 511));
      pre = $urandom;
      data = ~pre;
      poke(1'b1, addr, data);
      b_bus = ($urandom & ~32'h1FF) | 32'(addr);
      b_marin = 1'b1;
      nstep(1);
      b_marin = 1'b0;
      b_bus = pre;
      b_mdrin = 1'b1;
      nstep(1);
      b_mdrin = 1'b0;
      bz0 = b_busy_n;
      dn0 = b_done_n;
      rd0 = b_rd_n;
      b_read = 1'b1;
      b_mdrin = 1'b1;
      for (int e = 0; e <= B_RD; e++) begin
        nstep(1);
        tests++;
        if (b_mdr !== pre || b_done !== 1'b0) begin
          fails++;
          $display("FAIL lat_early k=%0d e=%0d: mdr=%h done=%b want %h 0", k, e, b_mdr, b_done, pre);
        end
      end
      nstep(1);
      tests++;
      if (b_mdr !== data || b_done !== 1'b1) begin
        fails++;
        $display("FAIL lat_capture k=%0d: mdr=%h done=%b want %h 1", k, b_mdr, b_done, data);
      end
      b_read = 1'b0;
      b_mdrin = 1'b0;
      nstep(2);
      tests++;
      if (b_busy_n - bz0 != B_RD + 2 || b_done_n - dn0 != 1 || b_rd_n - rd0 != 1) begin
        fails++;
        $display("FAIL lat_busy k=%0d: busy_cycles=%0d dones=%0d rd_pulses=%0d want %0d 1 1",
                 k, b_busy_n - bz0, b_done_n - dn0, b_rd_n - rd0, B_RD + 2);
      end
      data = $urandom;
      b_bus = data;
      b_mdrin = 1'b1;
      nstep(1);
      b_mdrin = 1'b0;
      wr0 = b_wr_n;
      b_wren = 1'b1;
      nstep(B_WR + 1);
      tests++;
      if (b_done !== 1'b0) begin
        fails++;
        $display("FAIL lat_wr_early k=%0d: done=%b want 0", k, b_done);
      end
      nstep(1);
      tests++;
      if (b_done !== 1'b1) begin
        fails++;
        $display("FAIL lat_wr_done k=%0d: done=%b want 1", k, b_done);
      end
      b_wren = 1'b0;
      nstep(2);
      tests++;
      if (b_wr_n - wr0 != 1 || b_wr_data !== data || b_err !== 1'b0) begin
        fails++;
        $display("FAIL lat_wr k=%0d: wr_pulses=%0d data=%h err=%b want 1 %h 0",
                 k, b_wr_n - wr0, b_wr_data, b_err, data);
      end
    end
  endtask

  initial begin
    a_bus = '0;
    b_bus = '0;
    poke_a = 1'b0;
    poke_b = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_conflict();
    test_proto_err();
    test_reset_mid();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
# mem_interface

Memory-side stage directly downstream of the control unit. Holds MAR and MDR and turns the control unit's `MARin`, `MDRin`, `read` and `wren` strobes into one-shot, latency-aware accesses to the synchronous 32-bit RAM. MDR contents are driven back onto the datapath bus. A `done`/`busy` handshake is provided so the sequencer can stall on slow memory.

## Interface
- `ADDR_W`, default 9: RAM address width; MAR keeps `bus_in[ADDR_W-1:0]`.
- `DATA_W`, default 32: word width.
- `RD_LAT`, default 1: cycles from the edge where the RAM samples `mem_rd` to the edge where `mem_rdata` is valid. Must be at least 1.
- `WR_LAT`, default 1: cycles from the edge where the RAM samples `mem_wr` to write completion. Must be at least 1.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `bus_in` in DATA_W: datapath bus.
- `MARin` in 1: load MAR from the bus.
- `MDRin` in 1: load MDR. Source is memory when `read` is also high, otherwise `bus_in`.
- `read` in 1: level request for a memory read.
- `wren` in 1: level request for a memory write.
- `mdr_out` out DATA_W: MDR contents, to the bus mux.
- `mem_addr` out ADDR_W: equal to MAR.
- `mem_wdata` out DATA_W: equal to MDR.
- `mem_rd` out 1: one-cycle read strobe to the RAM.
- `mem_wr` out 1: one-cycle write strobe to the RAM.
- `mem_rdata` in DATA_W: RAM read data.
- `busy` out 1: an access is in flight.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky protocol-error flag.

## Operation
- Reset values, applied asynchronously: MAR=0, MDR=0, state=IDLE, `mem_rd`=`mem_wr`=`busy`=`done`=`err`=0.
- Request detection:
  - `read` and `wren` are rising-edge detected against their values registered on the previous cycle.
  - A level held across several states therefore starts exactly one access.
- States:
  - IDLE: on a `wren` rise go to WR_ISSUE. Otherwise, on a `read` rise go to RD_ISSUE.
  - RD_ISSUE: `mem_rd`=1 for this one cycle. Load the counter with RD_LAT, then go to RD_WAIT.
  - RD_WAIT: decrement the counter. When it reaches 0, MDR captures `mem_rdata` on that edge and the state goes to DONE.
  - WR_ISSUE: `mem_wr`=1 and `mem_wdata`=MDR. Load the counter with WR_LAT, then go to WR_WAIT.
  - WR_WAIT: decrement the counter; at 0 go to DONE.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- `busy`=1 in every state except IDLE. It is registered, so it rises the cycle after acceptance.
- MAR loads `bus_in[ADDR_W-1:0]` on any edge where `MARin`=1 and the state is IDLE.
- MDR bus load: `MDRin`=1, `read`=0 and state IDLE → MDR ← `bus_in` on that edge. This load may coincide with a `wren` rise; the write then uses the newly loaded value.
- Simultaneous `read` and `wren` rises: the write is performed and the read is dropped; `err` is set.
- `MARin`, or an MDR bus load, while `busy` is high: ignored; `err` is set.
- A new rise of `read` or `wren` while `busy`: ignored; `err` is set.
- `err` clears only on reset.
- Reset asserted mid-access: outputs drop immediately, the access is abandoned, and no `done` is produced.

## Timing
- Read, with the rise sampled at edge E0:
  - `mem_rd` is high during E0–E1.
  - MDR is captured at E(1+RD_LAT).
  - `done` is high during the following cycle.
  - With RD_LAT=1: capture at E2, `done` during E2–E3, and a total of 3 cycles from request to `done`.
- Write, with the rise sampled at E0:
  - `mem_wr` is high during E0–E1 with address and data stable.
  - `done` is high during cycle E(1+WR_LAT) to E(2+WR_LAT).
- `mem_addr`, `mem_wdata` and `mdr_out` are register outputs with no combinational path from the inputs.
- `mem_rd` and `mem_wr` are decoded from state only, so they are glitch-free.

## Structure
- Shared package `cpu_pkg` holds:
  - the `mem_state_t` enum (IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE);
  - default widths ADDR_W and DATA_W.
- One sub-module, `mdr_reg`: the MDR with its bus/memory source mux and load enable.
- The FSM, latency counter, edge detectors and MAR live in `mem_interface`.

## Test plan
- Read, RD_LAT=1:
  - Stimulus: bus=0x0000_0055 with `MARin`; then `read`+`MDRin` held for 3 cycles; mem[0x55]=0xDEAD_BEEF.
  - Expected: a single `mem_rd` pulse with `mem_addr`=0x055, `mdr_out`=0xDEAD_BEEF at E2, one `done`.
- Write:
  - Stimulus: MAR=0x1F0; MDR loaded from bus 0x1234_5678; `wren` held for 4 cycles.
  - Expected: exactly one `mem_wr` pulse, data 0x1234_5678 at address 0x1F0, `done` at E(1+WR_LAT).
- Latency:
  - Stimulus: RD_LAT=4.
  - Expected: `busy` high for 6 cycles; MDR unchanged until E5.
- Conflict:
  - Stimulus: `read` and `wren` rise on the same edge.
  - Expected: write only, no `mem_rd`, `err`=1 and sticky.
- Protocol error:
  - Stimulus: `MARin` with bus=0x0AA mid-read.
  - Expected: MAR keeps its old value, the read completes normally, `err`=1.
- Reset:
  - Stimulus: `reset` pulled low during RD_WAIT.
  - Expected: `busy`, `mem_rd`, MAR and MDR go to 0 immediately; no `done` after release.
